fifo_rd_packer: RTL and testbench

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

---
 rtl/fifo_rd_packer_pkg.sv | 7 +
 rtl/fifo_rd_packer_beat_cnt.sv | 34 +++
 rtl/fifo_rd_packer.sv | 102 ++++++++++
 tb/tb_fifo_rd_packer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and default sizing for the FIFO read packer.
package fifo_rd_packer_pkg;
  typedef enum logic {FILL = 1'b0, SEND = 1'b1} state_e;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_FRAME_BEATS = 1024;
endpackage

// File: rtl/fifo_rd_packer_beat_cnt.sv
// Wrapping beat-within-frame counter; flags the final beat of a frame.
module pack_beat_cnt
  import fifo_rd_packer_pkg::*;
#(
  parameter int FrameBeats   = DEF_FRAME_BEATS,
  parameter int BeatCntWidth = $clog2(FrameBeats)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic last_o
);
  logic [BeatCntWidth-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == BeatCntWidth'(FrameBeats - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (inc_i && last_o)) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + BeatCntWidth'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fifo_rd_packer.sv
// Reads word pairs from a 1-cycle-latency FIFO and emits them as packed
// valid/ready beats, with frame-last marking and a half-beat flush.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int DataWidth    = DEF_DATA_WIDTH,
  parameter int FrameBeats   = DEF_FRAME_BEATS,
  parameter int BeatCntWidth = $clog2(FrameBeats)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  output logic                   fifo_rd,
  input  logic [DataWidth-1:0]   fifo_dout,
  input  logic                   flush,
  output logic [2*DataWidth-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last
);
  state_e               state_q;
  logic [1:0]           req_cnt_q;
  logic [1:0]           cap_cnt_q;
  logic                 rd_q;
  logic                 flush_q;
  logic [DataWidth-1:0] lo_q;
  logic [DataWidth-1:0] hi_q;
  logic                 flush_ok;
  logic                 hs;
  logic                 beat_clr;
  logic                 cnt_last;

  // Flush only makes sense with exactly one word held and nothing in flight.
  assign flush_ok = flush && (state_q == FILL) && (cap_cnt_q == 2'd1) && (req_cnt_q == 2'd1);
  assign fifo_rd  = !rst && (state_q == FILL) && (req_cnt_q < 2'd2) && !fifo_empty && !flush_ok;
  assign m_valid  = (state_q == SEND);
  assign hs       = m_valid && m_ready;
  assign beat_clr = hs && flush_q;
  assign m_last   = m_valid && (flush_q || cnt_last);
  assign m_data   = m_valid ? {hi_q, lo_q} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      req_cnt_q <= 2'd0;
      cap_cnt_q <= 2'd0;
      rd_q      <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      rd_q <= fifo_rd;
      unique case (state_q)
        FILL: begin
          if (fifo_rd) begin
            req_cnt_q <= req_cnt_q + 2'd1;
          end
          if (flush_ok) begin
            flush_q <= 1'b1;
            state_q <= SEND;
          end else if (rd_q) begin
            cap_cnt_q <= cap_cnt_q + 2'd1;
            if (cap_cnt_q == 2'd1) begin
              state_q <= SEND;
            end
          end
        end
        SEND: begin
          if (hs) begin
            state_q   <= FILL;
            req_cnt_q <= 2'd0;
            cap_cnt_q <= 2'd0;
            flush_q   <= 1'b0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  // Data capture: word arrives the cycle after its read strobe.
  always_ff @(posedge clk) begin
    if ((state_q == FILL) && rd_q) begin
      if (cap_cnt_q == 2'd0) begin
        lo_q <= fifo_dout;
      end else begin
        hi_q <= fifo_dout;
      end
    end else if (flush_ok) begin
      hi_q <= '0;
    end
  end

  pack_beat_cnt #(
    .FrameBeats  (FrameBeats),
    .BeatCntWidth(BeatCntWidth)
  ) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (hs),
    .clr_i (beat_clr),
    .last_o(cnt_last)
  );
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Randomized bench for fifo_rd_packer with an upstream FIFO model and a
// beat-level scoreboard derived from word pairing and frame position.
module tb_fifo_rd_packer;
  localparam int DW = 16;
  localparam int FB = 4;

  logic          clk;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] fifo_dout;
  logic          flush;
  logic [2*DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  fifo_rd_packer #(.DataWidth(DW), .FrameBeats(FB), .BeatCntWidth(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .fifo_dout (fifo_dout),
    .flush     (flush),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0]   fq[$];
  logic [2*DW-1:0] exp_d[$];
  logic            exp_l[$];
  int              frame_pos = 0;
  bit              hold_empty = 0;
  logic            rd_prev = 0;
  logic            prev_valid = 0;
  logic            prev_ready = 0;
  logic [2*DW-1:0] prev_data = '0;
  logic            prev_last = 0;
  logic            s_rd, s_valid, s_last;
  logic [2*DW-1:0] s_data;
  int              n_last_hs = 0;

  task automatic push_pair(input logic [DW-1:0] w0, input logic [DW-1:0] w1);
    fq.push_back(w0);
    fq.push_back(w1);
    exp_d.push_back({w1, w0});
    frame_pos++;
    if (frame_pos == FB) begin
      exp_l.push_back(1'b1);
      frame_pos = 0;
    end else begin
      exp_l.push_back(1'b0);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cyc(input bit rdy, input bit fl);
    logic [2*DW-1:0] ed;
    logic el;
    if (rd_prev === 1'b1 && fq.size() > 0) fifo_dout = fq.pop_front();
    fifo_empty = (fq.size() == 0) || hold_empty;
    m_ready = rdy;
    flush = fl;
    #1;
    s_rd = fifo_rd; s_valid = m_valid; s_data = m_data; s_last = m_last;
    if (fifo_empty) begin
      tests++;
      if (s_rd !== 1'b0) begin fails++; $display("FAIL rd_while_empty: fifo_rd=%b, required 0", s_rd); end
    end
    if (s_valid === 1'b1) begin
      tests++;
      if (s_rd !== 1'b0) begin fails++; $display("FAIL rd_in_send: fifo_rd=%b, required 0", s_rd); end
    end
    if (prev_valid === 1'b1 && prev_ready == 1'b0) begin
      tests++;
      if (s_valid !== 1'b1 || s_data !== prev_data || s_last !== prev_last) begin
        fails++;
        $display("FAIL hold_stable: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                 s_valid, s_data, s_last, prev_data, prev_last);
      end
    end
    if (s_valid === 1'b1 && rdy) begin
      tests++;
      if (exp_d.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat: data=%h, required no beat", s_data);
      end else begin
        ed = exp_d.pop_front();
        el = exp_l.pop_front();
        if (s_data !== ed || s_last !== el) begin
          fails++;
          $display("FAIL beat: data=%h last=%b, required data=%h last=%b", s_data, s_last, ed, el);
        end
        if (s_last === 1'b1) n_last_hs++;
      end
    end
    prev_valid = s_valid; prev_ready = rdy; prev_data = s_data; prev_last = s_last;
    rd_prev = s_rd;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic drain(input int budget, input int rdy_pct, input int stall_pct, input int flush_pct);
    int n;
    n = 0;
    while ((exp_d.size() > 0 || fq.size() > 0) && n < budget) begin
      hold_empty = ($urandom_range(99) < stall_pct);
      cyc($urandom_range(99) < rdy_pct, $urandom_range(99) < flush_pct);
      n++;
    end
    hold_empty = 0;
    tests++;
    if (exp_d.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_d.size());
    end
  endtask

  task automatic clear_model();
    fq.delete(); exp_d.delete(); exp_l.delete();
    frame_pos = 0; hold_empty = 0; rd_prev = 0; prev_valid = 0;
    fifo_empty = 1'b1; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_ready = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_ready = 1'b1;
    clear_model();
    repeat (3) @(negedge clk);
    #1;
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b, required 0", m_valid); end
    tests++; if (m_last !== 1'b0) begin fails++; $display("FAIL rst_last: got %b, required 0", m_last); end
    tests++; if (m_data !== '0) begin fails++; $display("FAIL rst_data: got %h, required 0", m_data); end
    tests++; if (fifo_rd !== 1'b0) begin fails++; $display("FAIL rst_rd: got %b, required 0", fifo_rd); end
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0);
    tests++; if (s_valid !== 1'b0) begin fails++; $display("FAIL post_rst_valid: got %b, required 0", s_valid); end
  endtask

  task automatic test_basic_timing();
    logic rdl[8];
    logic vl[8];
    int first_v;
    do_reset();
    push_pair(16'h1111, 16'h2222);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0);
      rdl[i] = s_rd; vl[i] = s_valid;
    end
    first_v = -1;
    for (int i = 7; i >= 0; i--) if (vl[i] === 1'b1) first_v = i;
    tests++;
    if (rdl[0] !== 1'b1 || rdl[1] !== 1'b1 || rdl[2] !== 1'b0) begin
      fails++; $display("FAIL basic_rd_pattern: got %b%b%b, required 110", rdl[0], rdl[1], rdl[2]);
    end
    tests++;
    if (first_v != 3) begin fails++; $display("FAIL basic_latency: valid at cycle %0d, required 3", first_v); end
    tests++;
    if (exp_d.size() != 0) begin fails++; $display("FAIL basic_beat_missing: %0d left, required 0", exp_d.size()); end
  endtask

  task automatic test_backpressure();
    int rds;
    do_reset();
    push_pair(DW'($urandom), DW'($urandom));
    push_pair(DW'($urandom), DW'($urandom));
    rds = 0;
    for (int i = 0; i < 13; i++) begin
      cyc(1'b0, 1'b0);
      if (s_rd === 1'b1) rds++;
    end
    tests++;
    if (s_valid !== 1'b1 || s_data !== exp_d[0]) begin
      fails++; $display("FAIL bp_first_beat: valid=%b data=%h, required valid=1 data=%h", s_valid, s_data, exp_d[0]);
    end
    tests++;
    if (rds != 2) begin fails++; $display("FAIL bp_read_count: got %0d reads, required 2", rds); end
    drain(200, 100, 0, 0);
  endtask

  task automatic test_frame_last();
    int base;
    do_reset();
    base = n_last_hs;
    for (int i = 0; i < 8; i++) push_pair(DW'($urandom), DW'($urandom));
    drain(400, 100, 0, 0);
    tests++;
    if (n_last_hs - base != 2) begin
      fails++; $display("FAIL frame_last_count: got %0d, required 2", n_last_hs - base);
    end
  endtask

  task automatic test_flush();
    int vcnt;
    do_reset();
    push_pair(DW'($urandom), DW'($urandom));
    drain(50, 100, 0, 0);
    fq.push_back(16'hABCD);
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0);
      if (s_valid === 1'b1) vcnt++;
    end
    tests++;
    if (vcnt != 0) begin fails++; $display("FAIL half_beat_waits: valid seen %0d times, required 0", vcnt); end
    exp_d.push_back({16'h0000, 16'hABCD});
    exp_l.push_back(1'b1);
    frame_pos = 0;
    cyc(1'b1, 1'b1);
    drain(50, 100, 0, 0);
    for (int i = 0; i < 4; i++) push_pair(DW'($urandom), DW'($urandom));
    drain(200, 100, 0, 0);
  endtask

  task automatic test_flush_ignored();
    do_reset();
    push_pair(DW'($urandom), DW'($urandom));
    push_pair(DW'($urandom), DW'($urandom));
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    drain(100, 100, 0, 0);
    for (int i = 0; i < 20; i++) push_pair(DW'($urandom), DW'($urandom));
    drain(2000, 60, 0, 30);
  endtask

  task automatic test_random_stream();
    do_reset();
    for (int i = 0; i < 24; i++) push_pair(DW'($urandom), DW'($urandom));
    drain(3000, 70, 30, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_pair(16'h1234, 16'h5678);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    rst = 1'b1;
    clear_model();
    #1;
    tests++; if (fifo_rd !== 1'b0) begin fails++; $display("FAIL mid_rst_rd: got %b, required 0", fifo_rd); end
    @(negedge clk);
    #1;
    tests++;
    if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0) begin
      fails++; $display("FAIL mid_rst_out: valid=%b data=%h last=%b, required 0 0 0", m_valid, m_data, m_last);
    end
    rst = 1'b0;
    @(negedge clk);
    cyc(1'b1, 1'b0);
    tests++; if (s_rd !== 1'b0) begin fails++; $display("FAIL mid_rst_idle_rd: got %b, required 0", s_rd); end
    for (int i = 0; i < 4; i++) push_pair(DW'($urandom), DW'($urandom));
    drain(200, 100, 0, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
    @(negedge clk);
    test_reset();
    test_basic_timing();
    test_backpressure();
    test_frame_last();
    test_flush();
    test_flush_ignored();
    test_random_stream();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
